// File: rtl/tone_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tone_meter
//  Description : Measures the period (in clk cycles) of an asynchronous
//                square-wave input. Each new period is reported with a
//                one-cycle valid strobe. A lock flag indicates that
//                consecutive periods agree within TOLERANCE. A silence
//                timeout returns the block to idle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock
//    rst_n        in   asynchronous active-low reset
//    ena          in   block enable; low = synchronous clear to idle
//    tone_in      in   asynchronous square-wave input
//    period       out  last measured period in clk cycles
//    period_valid out  one-cycle strobe when period updates
//    locked       out  consecutive periods within TOLERANCE
//    no_tone      out  idle / silence indicator
// ============================================================================
module tone_meter #(
    parameter int WIDTH_COUNTER = 10,
    parameter int TIMEOUT       = 1000,
    parameter int TOLERANCE     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     tone_in,
    output logic [WIDTH_COUNTER-1:0] period,
    output logic                     period_valid,
    output logic                     locked,
    output logic                     no_tone
);

    localparam logic [WIDTH_COUNTER-1:0] C_TIMEOUT = WIDTH_COUNTER'(TIMEOUT);
    localparam logic [WIDTH_COUNTER:0]   C_TOL     = (WIDTH_COUNTER+1)'(TOLERANCE);
    localparam logic [WIDTH_COUNTER-1:0] C_ONE     = WIDTH_COUNTER'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_MEAS  = 2'd2
    } state_t;

    // Input synchronizer and edge detector
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [WIDTH_COUNTER-1:0] r_cnt;
    logic [WIDTH_COUNTER-1:0] w_cnt_nxt;
    logic [WIDTH_COUNTER-1:0] r_period;
    logic [WIDTH_COUNTER-1:0] w_period_nxt;
    logic                     r_valid;
    logic                     w_valid_nxt;
    logic                     r_locked;
    logic                     w_locked_nxt;
    logic                     r_no_tone;
    logic                     w_no_tone_nxt;

    logic                     w_rise;
    logic                     w_timeout;
    logic [WIDTH_COUNTER:0]   w_cnt_ext;
    logic [WIDTH_COUNTER:0]   w_per_ext;
    logic [WIDTH_COUNTER:0]   w_diff;
    logic                     w_within;

    // The synchronizer keeps sampling while ena is low so that a stale
    // high level is not mistaken for a fresh edge after re-enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= tone_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise    = r_sync2 & ~r_prev;
    assign w_timeout = (r_cnt == C_TIMEOUT);

    // One extra bit so the absolute difference never wraps.
    assign w_cnt_ext = {1'b0, r_cnt};
    assign w_per_ext = {1'b0, r_period};
    assign w_diff    = (w_cnt_ext >= w_per_ext) ? (w_cnt_ext - w_per_ext)
                                                : (w_per_ext - w_cnt_ext);
    assign w_within  = (w_diff <= C_TOL);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_period_nxt  = r_period;
        w_valid_nxt   = 1'b0;
        w_locked_nxt  = r_locked;
        w_no_tone_nxt = r_no_tone;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_rise) begin
                    w_state_nxt   = S_ARMED;
                    w_cnt_nxt     = C_ONE;
                    w_no_tone_nxt = 1'b0;
                end
            end
            S_ARMED, S_MEAS: begin
                if (w_rise) begin
                    w_cnt_nxt = C_ONE;
                    if (w_timeout) begin
                        // Edge arriving exactly at the timeout starts a
                        // fresh measurement instead of reporting a period.
                        w_state_nxt  = S_ARMED;
                        w_locked_nxt = 1'b0;
                    end else begin
                        w_state_nxt  = S_MEAS;
                        w_period_nxt = r_cnt;
                        w_valid_nxt  = 1'b1;
                        // The first period after arming has no predecessor.
                        w_locked_nxt = (r_state == S_MEAS) && w_within;
                    end
                end else if (w_timeout) begin
                    w_state_nxt   = S_IDLE;
                    w_cnt_nxt     = '0;
                    w_period_nxt  = '0;
                    w_locked_nxt  = 1'b0;
                    w_no_tone_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_cnt_nxt     = '0;
                w_period_nxt  = '0;
                w_locked_nxt  = 1'b0;
                w_no_tone_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_no_tone <= 1'b1;
        end else if (!ena) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_no_tone <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_period  <= w_period_nxt;
            r_valid   <= w_valid_nxt;
            r_locked  <= w_locked_nxt;
            r_no_tone <= w_no_tone_nxt;
        end
    end

    assign period       = r_period;
    assign period_valid = r_valid;
    assign locked       = r_locked;
    assign no_tone      = r_no_tone;

endmodule
`default_nettype wire

// File: tb/tb_tone_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tone_meter
//  Description : Self-checking bench for tone_meter. A behavioural model
//                tracks the clock index of each detected rising edge and
//                derives period, strobe, lock and silence from the time
//                between edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_meter;

    localparam int W   = 10;
    localparam int TO  = 1000;
    localparam int TOL = 2;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         ena     = 1'b0;
    logic         tone_in = 1'b0;
    logic [W-1:0] period;
    logic         period_valid;
    logic         locked;
    logic         no_tone;

    tone_meter #(
        .WIDTH_COUNTER (W),
        .TIMEOUT       (TO),
        .TOLERANCE     (TOL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .tone_in      (tone_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .no_tone      (no_tone)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int           m_cyc   = 0;   // posedge index
    int           m_last  = 0;   // posedge index of the last accepted edge
    int           m_edges = 0;   // 0 silent, 1 one edge seen, 2 measuring
    logic         h1 = 1'b0, h2 = 1'b0, h3 = 1'b0; // tone_in seen 1/2/3 edges ago
    logic [W-1:0] e_period  = '0;
    logic         e_valid   = 1'b0;
    logic         e_locked  = 1'b0;
    logic         e_no_tone = 1'b1;

    int           strobes = 0;
    logic [W-1:0] last_p  = '0;
    logic         last_l  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input bit clr_hist);
        m_edges   = 0;
        e_period  = '0;
        e_valid   = 1'b0;
        e_locked  = 1'b0;
        e_no_tone = 1'b1;
        if (clr_hist) begin
            h1 = 1'b0;
            h2 = 1'b0;
            h3 = 1'b0;
        end
    endtask

    // One clock edge of the reference: an edge is recognised when the input
    // was high two samples ago and low three samples ago.
    task automatic model_edge();
        automatic logic s    = tone_in;
        automatic logic rise = h2 & ~h3;
        automatic int   d;
        automatic int   ad;
        m_cyc++;
        e_valid = 1'b0;
        if (!rst_n) begin
            model_clear(1'b1);
            return;
        end
        if (!ena) begin
            model_clear(1'b0);
        end else if (rise) begin
            d = m_cyc - m_last;
            if (m_edges == 0 || d >= TO) begin
                m_edges   = 1;
                e_no_tone = 1'b0;
                e_locked  = 1'b0;
            end else begin
                ad = d - int'(e_period);
                if (ad < 0) ad = -ad;
                e_locked = (m_edges == 2) && (ad <= TOL);
                e_period = W'(d);
                e_valid  = 1'b1;
                m_edges  = 2;
            end
            m_last = m_cyc;
        end else if (m_edges != 0 && (m_cyc - m_last) == TO) begin
            model_clear(1'b0);
        end
        h3 = h2;
        h2 = h1;
        h1 = s;
    endtask

    task automatic step(input logic tin);
        @(negedge clk);
        tone_in = tin;
        @(posedge clk);
        model_edge();
        #1;
        chk("period",       32'(period),       32'(e_period));
        chk("period_valid", 32'(period_valid), 32'(e_valid));
        chk("locked",       32'(locked),       32'(e_locked));
        chk("no_tone",      32'(no_tone),      32'(e_no_tone));
        if (period_valid) begin
            strobes++;
            last_p = period;
            last_l = locked;
        end
    endtask

    task automatic wave(input int p, input int h);
        for (int i = 0; i < h; i++)     step(1'b1);
        for (int i = 0; i < p - h; i++) step(1'b0);
    endtask

    initial begin
        int s0;
        int base;
        int p;
        int h;

        // Reset held while the input toggles
        rst_n = 1'b0;
        ena   = 1'b1;
        for (int i = 0; i < 8; i++) step(i[0]);
        chk("rst_period",  32'(period),       32'd0);
        chk("rst_valid",   32'(period_valid), 32'd0);
        chk("rst_locked",  32'(locked),       32'd0);
        chk("rst_no_tone", 32'(no_tone),      32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0);
        chk("post_rst_no_tone", 32'(no_tone), 32'd1);

        // Steady 86-cycle tone
        s0 = strobes;
        wave(86, 43);
        chk("first_rise_no_tone", 32'(no_tone), 32'd0);
        chk("first_rise_strobes", 32'(strobes - s0), 32'd0);
        wave(86, 43);
        chk("second_rise_period", 32'(last_p), 32'd86);
        chk("second_rise_locked", 32'(last_l), 32'd0);
        wave(86, 43);
        chk("third_rise_locked", 32'(last_l), 32'd1);
        wave(86, 43);
        chk("steady_strobes", 32'(strobes - s0), 32'd3);

        // Frequency step to 100
        wave(100, 50);
        wave(100, 50);
        chk("step_period", 32'(last_p), 32'd100);
        chk("step_locked", 32'(last_l), 32'd0);
        wave(100, 50);
        chk("step_relock", 32'(last_l), 32'd1);

        // Jitter inside and outside tolerance
        wave(86, 43);
        wave(88, 44);
        wave(86, 43);
        chk("jitter88_locked", 32'(last_l), 32'd1);
        wave(86, 43);
        chk("jitter86_locked", 32'(last_l), 32'd1);
        wave(89, 44);
        wave(86, 43);
        chk("jitter89_period", 32'(last_p), 32'd89);
        chk("jitter89_locked", 32'(last_l), 32'd0);

        // Silence
        s0 = strobes;
        for (int i = 0; i < 1100; i++) step(1'b0);
        chk("silence_no_tone", 32'(no_tone), 32'd1);
        chk("silence_period",  32'(period),  32'd0);
        chk("silence_locked",  32'(locked),  32'd0);
        chk("silence_strobes", 32'(strobes - s0), 32'd0);

        // Edge landing exactly on the timeout re-arms without a strobe
        wave(86, 43);
        wave(TO, TO / 2);
        s0 = strobes;
        wave(86, 43);
        chk("timeout_edge_strobes", 32'(strobes - s0), 32'd0);
        chk("timeout_edge_no_tone", 32'(no_tone), 32'd0);
        wave(86, 43);
        chk("after_rearm_strobes", 32'(strobes - s0), 32'd1);

        // Asynchronous reset glitch while locked
        wave(86, 43);
        wave(86, 43);
        chk("pre_glitch_locked", 32'(locked), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("glitch_period",  32'(period),       32'd0);
        chk("glitch_valid",   32'(period_valid), 32'd0);
        chk("glitch_locked",  32'(locked),       32'd0);
        chk("glitch_no_tone", 32'(no_tone),      32'd1);
        rst_n = 1'b1;
        model_clear(1'b1);
        wave(86, 43);
        wave(86, 43);
        wave(86, 43);
        chk("post_glitch_locked", 32'(locked), 32'd1);

        // Enable dropped for five cycles while locked
        ena = 1'b0;
        for (int i = 0; i < 5; i++) step(i < 2);
        chk("ena_low_no_tone", 32'(no_tone), 32'd1);
        chk("ena_low_locked",  32'(locked),  32'd0);
        ena = 1'b1;
        s0 = strobes;
        wave(86, 43);
        chk("ena_first_rise_strobes", 32'(strobes - s0), 32'd0);
        wave(86, 43);
        chk("ena_second_rise_strobes", 32'(strobes - s0), 32'd1);
        chk("ena_second_rise_locked",  32'(last_l), 32'd0);

        // Randomized periods with jitter and occasional enable dips
        base = 86;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) base = int'($urandom_range(20, 200));
            p = base + int'($urandom_range(0, 6)) - 3;
            if ($urandom_range(0, 9) == 0) p = int'($urandom_range(2, 6));
            h = int'($urandom_range(1, p - 1));
            wave(p, h);
            if ($urandom_range(0, 19) == 0) begin
                ena = 1'b0;
                for (int i = 0; i < 3; i++) step(1'b0);
                ena = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
